// File: rtl/cmd_stream_counter.sv
// Passive per-accelerator command counter for the command-in and command-out streams.
// Each packet counts once, on its header beat, two edges after the beat is taken.
module cmd_stream_counter #(
  parameter int MAX_ACCS = 16,
  parameter int ID_W     = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            clear,
  input  logic            cmd_in_tvalid,
  input  logic            cmd_in_tready,
  input  logic            cmd_in_tlast,
  input  logic [ID_W-1:0] cmd_in_tdest,
  input  logic            cmd_out_tvalid,
  input  logic            cmd_out_tready,
  input  logic            cmd_out_tlast,
  input  logic [ID_W-1:0] cmd_out_tid,
  output logic [31:0]     cmd_in_n_cmds  [MAX_ACCS],
  output logic [31:0]     cmd_out_n_cmds [MAX_ACCS],
  output logic            bad_id
);

  localparam logic [0:0] ST_HEADER = 1'b0;
  localparam logic [0:0] ST_BODY   = 1'b1;

  // Counters wrap modulo 2^32; software works with differences.
  function automatic logic [31:0] wrap_inc(input logic [31:0] cnt);
    return cnt + 32'd1;
  endfunction

  function automatic logic [0:0] next_state(input logic [0:0] st, input logic beat,
                                            input logic last);
    logic [0:0] nxt;
    nxt = st;
    if (beat) begin
      if (st == ST_HEADER && !last) nxt = ST_BODY;
      else if (st == ST_BODY && last) nxt = ST_HEADER;
    end
    return nxt;
  endfunction

  logic                           in_beat, out_beat;
  logic [0:0]                     in_state_q, in_state_d;
  logic [0:0]                     out_state_q, out_state_d;
  logic                           in_ev_vld_q, in_ev_vld_d;
  logic                           out_ev_vld_q, out_ev_vld_d;
  logic [ID_W-1:0]                in_ev_id_q, in_ev_id_d;
  logic [ID_W-1:0]                out_ev_id_q, out_ev_id_d;
  logic [MAX_ACCS-1:0][31:0]      in_cnt_q, in_cnt_d;
  logic [MAX_ACCS-1:0][31:0]      out_cnt_q, out_cnt_d;
  logic                           bad_id_q, bad_id_d;
  logic                           in_hit, out_hit;

  assign in_beat  = cmd_in_tvalid & cmd_in_tready;
  assign out_beat = cmd_out_tvalid & cmd_out_tready;

  // Stage E0: packet tracking and header-event capture
  always_comb begin
    in_state_d   = next_state(in_state_q, in_beat, cmd_in_tlast);
    out_state_d  = next_state(out_state_q, out_beat, cmd_out_tlast);
    in_ev_vld_d  = in_beat & (in_state_q == ST_HEADER);
    out_ev_vld_d = out_beat & (out_state_q == ST_HEADER);
    in_ev_id_d   = in_beat ? cmd_in_tdest : in_ev_id_q;
    out_ev_id_d  = out_beat ? cmd_out_tid : out_ev_id_q;
  end

  // Stage E1: apply captured events; clear discards whatever is in the stage this edge
  always_comb begin
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    bad_id_d  = bad_id_q;
    in_hit    = 1'b0;
    out_hit   = 1'b0;
    if (clear) begin
      in_cnt_d  = '0;
      out_cnt_d = '0;
      bad_id_d  = 1'b0;
    end else begin
      for (int i = 0; i < MAX_ACCS; i++) begin
        if (in_ev_vld_q && in_ev_id_q == ID_W'(i)) begin
          in_cnt_d[i] = wrap_inc(in_cnt_q[i]);
          in_hit      = 1'b1;
        end
        if (out_ev_vld_q && out_ev_id_q == ID_W'(i)) begin
          out_cnt_d[i] = wrap_inc(out_cnt_q[i]);
          out_hit      = 1'b1;
        end
      end
      if ((in_ev_vld_q && !in_hit) || (out_ev_vld_q && !out_hit)) bad_id_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      in_state_q   <= ST_HEADER;
      out_state_q  <= ST_HEADER;
      in_ev_vld_q  <= 1'b0;
      out_ev_vld_q <= 1'b0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      bad_id_q     <= 1'b0;
    end else begin
      in_state_q   <= in_state_d;
      out_state_q  <= out_state_d;
      in_ev_vld_q  <= in_ev_vld_d;
      out_ev_vld_q <= out_ev_vld_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      bad_id_q     <= bad_id_d;
    end
  end

  always_ff @(posedge clk) begin
    in_ev_id_q  <= in_ev_id_d;
    out_ev_id_q <= out_ev_id_d;
  end

  always_comb begin
    for (int i = 0; i < MAX_ACCS; i++) begin
      cmd_in_n_cmds[i]  = in_cnt_q[i];
      cmd_out_n_cmds[i] = out_cnt_q[i];
    end
  end

  assign bad_id = bad_id_q;

endmodule

// File: tb/tb_cmd_stream_counter.sv
// Directed bench for cmd_stream_counter: inputs driven after the falling edge,
// outputs checked at the next falling edge against hand-maintained expected counts.
module tb_cmd_stream_counter;

  localparam int MAX_ACCS = 16;
  localparam int ID_W     = 8;

  logic            clk = 1'b0;
  logic            rstn;
  logic            clear;
  logic            cmd_in_tvalid, cmd_in_tready, cmd_in_tlast;
  logic [ID_W-1:0] cmd_in_tdest;
  logic            cmd_out_tvalid, cmd_out_tready, cmd_out_tlast;
  logic [ID_W-1:0] cmd_out_tid;
  logic [31:0]     cmd_in_n_cmds  [MAX_ACCS];
  logic [31:0]     cmd_out_n_cmds [MAX_ACCS];
  logic            bad_id;

  logic [31:0]     exp_in  [MAX_ACCS];
  logic [31:0]     exp_out [MAX_ACCS];
  logic            exp_bad;
  logic [MAX_ACCS-1:0][31:0] cnt_img;
  int              errors = 0;
  int              checks = 0;

  cmd_stream_counter #(.MAX_ACCS(MAX_ACCS), .ID_W(ID_W)) dut (
    .clk(clk), .rstn(rstn), .clear(clear),
    .cmd_in_tvalid(cmd_in_tvalid), .cmd_in_tready(cmd_in_tready),
    .cmd_in_tlast(cmd_in_tlast), .cmd_in_tdest(cmd_in_tdest),
    .cmd_out_tvalid(cmd_out_tvalid), .cmd_out_tready(cmd_out_tready),
    .cmd_out_tlast(cmd_out_tlast), .cmd_out_tid(cmd_out_tid),
    .cmd_in_n_cmds(cmd_in_n_cmds), .cmd_out_n_cmds(cmd_out_n_cmds),
    .bad_id(bad_id)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < MAX_ACCS; i++) begin
      check32($sformatf("%s_in%0d", tag, i), cmd_in_n_cmds[i], exp_in[i]);
      check32($sformatf("%s_out%0d", tag, i), cmd_out_n_cmds[i], exp_out[i]);
    end
    check32($sformatf("%s_bad", tag), {31'b0, bad_id}, {31'b0, exp_bad});
  endtask

  task automatic idle();
    cmd_in_tvalid  = 1'b0; cmd_in_tready  = 1'b1; cmd_in_tlast = 1'b0; cmd_in_tdest = '0;
    cmd_out_tvalid = 1'b0; cmd_out_tready = 1'b1; cmd_out_tlast = 1'b0; cmd_out_tid = '0;
  endtask

  initial begin
    for (int i = 0; i < MAX_ACCS; i++) begin
      exp_in[i]  = 32'd0;
      exp_out[i] = 32'd0;
    end
    exp_bad = 1'b0;
    rstn  = 1'b0;
    clear = 1'b0;
    idle();
    tick();
    tick();
    check_all("reset");
    rstn = 1'b1;
    tick();

    // Three back-to-back single-beat commands to accelerator 2
    cmd_in_tvalid = 1'b1; cmd_in_tlast = 1'b1; cmd_in_tdest = 8'd2;
    tick();
    check32("in2_e0", cmd_in_n_cmds[2], 32'd0);
    tick();
    check32("in2_e1", cmd_in_n_cmds[2], 32'd1);
    tick();
    check32("in2_e2", cmd_in_n_cmds[2], 32'd2);
    idle();
    tick();
    check32("in2_e3", cmd_in_n_cmds[2], 32'd3);
    tick();
    exp_in[2] = 32'd3;
    check_all("single");

    // Four-beat out command to id 5 with valid gaps and tready held low
    cmd_out_tvalid = 1'b1; cmd_out_tid = 8'd5; cmd_out_tlast = 1'b0;
    tick();
    check32("out5_hdr", cmd_out_n_cmds[5], 32'd0);
    cmd_out_tvalid = 1'b0;
    tick();
    check32("out5_lat2", cmd_out_n_cmds[5], 32'd1);
    cmd_out_tvalid = 1'b1; cmd_out_tready = 1'b0; cmd_out_tid = 8'd7;
    tick();
    tick();
    cmd_out_tready = 1'b1; cmd_out_tid = 8'd5;
    tick();
    tick();
    cmd_out_tvalid = 1'b0;
    tick();
    cmd_out_tvalid = 1'b1; cmd_out_tlast = 1'b1;
    tick();
    idle();
    tick();
    tick();
    exp_out[5] = 32'd1;
    check_all("multi");

    // Same-cycle in and out headers to id 0
    cmd_in_tvalid  = 1'b1; cmd_in_tlast  = 1'b1; cmd_in_tdest = 8'd0;
    cmd_out_tvalid = 1'b1; cmd_out_tlast = 1'b1; cmd_out_tid  = 8'd0;
    tick();
    idle();
    check32("sim_in0_e0", cmd_in_n_cmds[0], 32'd0);
    check32("sim_out0_e0", cmd_out_n_cmds[0], 32'd0);
    tick();
    check32("sim_in0_e1", cmd_in_n_cmds[0], 32'd1);
    check32("sim_out0_e1", cmd_out_n_cmds[0], 32'd1);
    exp_in[0] = 32'd1; exp_out[0] = 32'd1;

    // Wrap: preload counter 1 with all-ones, then one header
    cnt_img = dut.in_cnt_q;
    cnt_img[1] = 32'hFFFF_FFFF;
    force dut.in_cnt_q = cnt_img;
    #1;
    release dut.in_cnt_q;
    check32("wrap_pre", cmd_in_n_cmds[1], 32'hFFFF_FFFF);
    tick();
    cmd_in_tvalid = 1'b1; cmd_in_tlast = 1'b1; cmd_in_tdest = 8'd1;
    tick();
    idle();
    tick();
    check32("wrap_post", cmd_in_n_cmds[1], 32'd0);
    check_all("wrap");

    // Out-of-range header followed by a body beat whose id is valid
    cmd_in_tvalid = 1'b1; cmd_in_tlast = 1'b0; cmd_in_tdest = 8'(MAX_ACCS);
    tick();
    check32("bad_e0", {31'b0, bad_id}, 32'd0);
    cmd_in_tlast = 1'b1; cmd_in_tdest = 8'd2;
    tick();
    idle();
    check32("bad_e1", {31'b0, bad_id}, 32'd1);
    tick();
    tick();
    exp_bad = 1'b1;
    check_all("badid");

    // Clear with one event in the stage and a new beat on the clear edge
    cmd_in_tvalid = 1'b1; cmd_in_tlast = 1'b1; cmd_in_tdest = 8'd4;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    idle();
    for (int i = 0; i < MAX_ACCS; i++) begin
      exp_in[i]  = 32'd0;
      exp_out[i] = 32'd0;
    end
    exp_bad = 1'b0;
    check_all("clr_e");
    tick();
    exp_in[4] = 32'd1;
    check_all("clr_e1");

    // Reset after beat 2 of a 4-beat command, then one single-beat command
    cmd_in_tvalid = 1'b1; cmd_in_tlast = 1'b0; cmd_in_tdest = 8'd3;
    tick();
    tick();
    idle();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    exp_in[4] = 32'd0;
    check_all("rst_mid");
    cmd_in_tvalid = 1'b1; cmd_in_tlast = 1'b1; cmd_in_tdest = 8'd3;
    tick();
    idle();
    tick();
    tick();
    check32("rst_in3", cmd_in_n_cmds[3], 32'd1);
    exp_in[3] = 32'd1;
    check_all("rst_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
